// File: rtl/bk16_adder.sv
// 16-bit unsigned adder on a hard-wired Brent-Kung prefix tree; sum and carry-out registered.
// Optional operand registers (adds one cycle of latency) when BK16_IN_REG_EN is defined.
module bk16_adder (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        Cout
);

  // Group (generate, propagate) pair flowing through the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Black cell: full prefix operator, keeps both G and P for later levels.
  function automatic gp_t black(input gp_t hi, input gp_t lo);
    gp_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

  // Gray cell: right operand spans down to bit 0, so only the group generate is needed.
  function automatic logic gray(input gp_t hi, input logic lo_g);
    return hi.g | (hi.p & lo_g);
  endfunction

  logic [15:0] w_a;
  logic [15:0] w_b;

`ifdef BK16_IN_REG_EN
  logic [15:0] r_a;
  logic [15:0] r_b;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= A;
      r_b <= B;
    end
  end

  assign w_a = r_a;
  assign w_b = r_b;
`else
  assign w_a = A;
  assign w_b = B;
`endif

  // Bit-level generate/propagate.
  logic [15:0] w_g;
  logic [15:0] w_p;
  gp_t  [15:1] w_bit;

  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;

  for (genvar i = 1; i < 16; i++) begin : g_leaf
    assign w_bit[i] = '{g: w_g[i], p: w_p[i]};
  end

  // Carry into bit i+1, i.e. group generate G[i:0].
  logic w_c0,  w_c1,  w_c2,  w_c3,  w_c4,  w_c5,  w_c6,  w_c7;
  logic w_c8,  w_c9,  w_c10, w_c11, w_c12, w_c13, w_c14, w_c15;

  // Up-sweep level 1 (span 2).
  gp_t w_3_2, w_5_4, w_7_6, w_9_8, w_11_10, w_13_12, w_15_14;

  assign w_c0    = w_g[0];
  assign w_c1    = gray(w_bit[1], w_c0);
  assign w_3_2   = black(w_bit[3],  w_bit[2]);
  assign w_5_4   = black(w_bit[5],  w_bit[4]);
  assign w_7_6   = black(w_bit[7],  w_bit[6]);
  assign w_9_8   = black(w_bit[9],  w_bit[8]);
  assign w_11_10 = black(w_bit[11], w_bit[10]);
  assign w_13_12 = black(w_bit[13], w_bit[12]);
  assign w_15_14 = black(w_bit[15], w_bit[14]);

  // Up-sweep level 2 (span 4).
  gp_t w_7_4, w_11_8, w_15_12;

  assign w_c3    = gray(w_3_2, w_c1);
  assign w_7_4   = black(w_7_6,   w_5_4);
  assign w_11_8  = black(w_11_10, w_9_8);
  assign w_15_12 = black(w_15_14, w_13_12);

  // Up-sweep levels 3 and 4 (spans 8 and 16).
  gp_t w_15_8;

  assign w_c7   = gray(w_7_4, w_c3);
  assign w_15_8 = black(w_15_12, w_11_8);
  assign w_c15  = gray(w_15_8, w_c7);

  // Down-sweep: fill the odd carries the up-sweep left open.
  assign w_c11 = gray(w_11_8,  w_c7);
  assign w_c5  = gray(w_5_4,   w_c3);
  assign w_c9  = gray(w_9_8,   w_c7);
  assign w_c13 = gray(w_13_12, w_c11);

  // Down-sweep final level: each even bit folds onto the carry below it.
  assign w_c2  = gray(w_bit[2],  w_c1);
  assign w_c4  = gray(w_bit[4],  w_c3);
  assign w_c6  = gray(w_bit[6],  w_c5);
  assign w_c8  = gray(w_bit[8],  w_c7);
  assign w_c10 = gray(w_bit[10], w_c9);
  assign w_c12 = gray(w_bit[12], w_c11);
  assign w_c14 = gray(w_bit[14], w_c13);

  logic [14:0] w_carry;
  logic [15:0] w_sum;

  assign w_carry = {w_c14, w_c13, w_c12, w_c11, w_c10, w_c9, w_c8,
                    w_c7,  w_c6,  w_c5,  w_c4,  w_c3,  w_c2, w_c1, w_c0};
  assign w_sum   = w_p ^ {w_carry, 1'b0};

  logic [15:0] r_sum;
  logic        r_cout;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_c15;
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_bk16_adder.sv
// Self-checking bench for bk16_adder: directed corner cases, reset behaviour and a
// randomized stream against a plain 17-bit A+B reference. Honours BK16_IN_REG_EN.
module tb_bk16_adder;

`ifdef BK16_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [15:0] A, B;
  logic [15:0] Sum;
  logic        Cout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] exp_q[$];

  always #5 Clk = ~Clk;

  bk16_adder dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .A    (A),
    .B    (B),
    .Sum  (Sum),
    .Cout (Cout)
  );

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // One cycle of streaming: apply a pair, clock once, report the result due now (if any).
  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      output bit have, output logic [16:0] expv, output logic [16:0] got);
    A = a;
    B = b;
    exp_q.push_back(ref_add(a, b));
    @(posedge Clk);
    #1;
    got  = {Cout, Sum};
    have = 1'b0;
    expv = '0;
    if (exp_q.size() == LAT) begin
      expv = exp_q.pop_front();
      have = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [16:0] expv;
    Rst_n = 1'b0;
    A = 16'hFFFF;
    B = 16'h0001;
    #2;
    n_cmp++;
    if ({Cout, Sum} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_t0: got %h expected %h", {Cout, Sum}, 17'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      n_cmp++;
      if ({Cout, Sum} !== 17'h0) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, {Cout, Sum}, 17'h0);
      end
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    // With operand registers the first edge still shows 0+0.
    expv = (LAT == 2) ? 17'h0 : 17'h1_0000;
    n_cmp++;
    if ({Cout, Sum} !== expv) begin
      n_bad++;
      $display("FAIL first_after_release: got %h expected %h", {Cout, Sum}, expv);
    end
    @(posedge Clk);
    #1;
    n_cmp++;
    if ({Cout, Sum} !== 17'h1_0000) begin
      n_bad++;
      $display("FAIL second_after_release: got %h expected %h", {Cout, Sum}, 17'h1_0000);
    end
  endtask

  task automatic test_directed;
    logic [15:0] a_t [6] = '{16'h3524, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFF};
    logic [15:0] b_t [6] = '{16'h5E81, 16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'h0000};
    logic [16:0] e_t [6] = '{17'h0_93A5, 17'h1_0000, 17'h1_FFFE, 17'h1_0000, 17'h0_0000, 17'h0_FFFF};
    for (int k = 0; k < 6; k++) begin
      A = a_t[k];
      B = b_t[k];
      repeat (LAT) @(posedge Clk);
      #1;
      n_cmp++;
      if ({Cout, Sum} !== e_t[k]) begin
        n_bad++;
        $display("FAIL directed[%0d] %h+%h: got %h expected %h", k, a_t[k], b_t[k], {Cout, Sum}, e_t[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a_t [3] = '{16'h0001, 16'h00FF, 16'h7FFF};
    logic [16:0] e_t [3] = '{17'h0_0002, 17'h0_0100, 17'h0_8000};
    bit          have;
    logic [16:0] expv, got;
    int          idx = 0;
    exp_q.delete();
    for (int k = 0; k < 3 + LAT - 1; k++) begin
      step(a_t[(k < 3) ? k : 2], 16'h0001, have, expv, got);
      if (have) begin
        n_cmp++;
        if (got !== expv || got !== e_t[idx]) begin
          n_bad++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", idx, got, e_t[idx]);
        end
        idx++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_midstream_reset;
    bit          have;
    logic [16:0] expv, got;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      step(16'($urandom), 16'($urandom), have, expv, got);
      if (have) begin
        n_cmp++;
        if (got !== expv) begin
          n_bad++;
          $display("FAIL pre_reset_stream[%0d]: got %h expected %h", k, got, expv);
        end
      end
    end
    A = 16'hFFFF;
    B = 16'hFFFF;
    @(negedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({Cout, Sum} !== 17'h0) begin
      n_bad++;
      $display("FAIL midstream_async_clear: got %h expected %h", {Cout, Sum}, 17'h0);
    end
    @(posedge Clk);
    #1;
    n_cmp++;
    if ({Cout, Sum} !== 17'h0) begin
      n_bad++;
      $display("FAIL midstream_reset_hold: got %h expected %h", {Cout, Sum}, 17'h0);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_q.delete();
    A = 16'h1234;
    B = 16'h4321;
    repeat (LAT) @(posedge Clk);
    #1;
    n_cmp++;
    if ({Cout, Sum} !== 17'h0_5555) begin
      n_bad++;
      $display("FAIL post_reset_pair: got %h expected %h", {Cout, Sum}, 17'h0_5555);
    end
  endtask

  task automatic test_random;
    bit          have;
    logic [16:0] expv, got;
    logic [15:0] a, b;
    exp_q.delete();
    for (int k = 0; k < 10000 + LAT - 1; k++) begin
      if (k < 10000) begin
        a = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       b = ~a;                            // all-propagate chains
          1:       b = ~a ^ (16'h1 << $urandom_range(0, 15));
          default: b = 16'($urandom);
        endcase
      end
      step(a, b, have, expv, got);
      if (have) begin
        n_cmp++;
        if (got !== expv) begin
          n_bad++;
          $display("FAIL random[%0d]: got %h expected %h", k, got, expv);
        end
      end
    end
    exp_q.delete();
  endtask

  initial begin
    A = '0;
    B = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
